// File: rtl/iob_cache_mem_arbiter.sv
// -----------------------------------------------------------------------------
// iob_cache_mem_arbiter
//
// Round-robin arbiter sharing one native memory port between N_MASTERS cache
// back-ends. One master owns the port at a time. The grant is held until that
// master's transfer completes. While the owner keeps m_lock high, the grant
// also survives across beats, so a multi-beat line fill or write-back is never
// interleaved with another master's traffic.
//
// Parameters:
//   N_MASTERS  number of requesting back-ends (>= 2)
//   ADDR_W     native address width
//   DATA_W     native data width (DATA_W/8 strobe bits)
//   MW         grant index width, derived from N_MASTERS
//
// Ports:
//   clk        clock
//   reset      synchronous, active-low reset
//   m_valid    per-master request, held until the matching m_ready
//   m_addr     per-master address, master i in [i*ADDR_W +: ADDR_W]
//   m_wdata    per-master write data
//   m_wstrb    per-master byte strobes (all zeros = read)
//   m_lock     per-master "keep the grant after this transfer"
//   m_rdata    read data, broadcast to every master
//   m_ready    per-master completion pulse
//   mem_*      back-end memory request / response
//   grant      one-hot current owner, zero while idle
// -----------------------------------------------------------------------------
module iob_cache_mem_arbiter #(
   parameter int N_MASTERS = 2,
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 64,
   parameter int MW        = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [N_MASTERS-1:0]            m_valid,
   input  logic [N_MASTERS*ADDR_W-1:0]     m_addr,
   input  logic [N_MASTERS*DATA_W-1:0]     m_wdata,
   input  logic [N_MASTERS*DATA_W/8-1:0]   m_wstrb,
   input  logic [N_MASTERS-1:0]            m_lock,
   output logic [DATA_W-1:0]               m_rdata,
   output logic [N_MASTERS-1:0]            m_ready,
   output logic                            mem_valid,
   output logic [ADDR_W-1:0]               mem_addr,
   output logic [DATA_W-1:0]               mem_wdata,
   output logic [DATA_W/8-1:0]             mem_wstrb,
   input  logic [DATA_W-1:0]               mem_rdata,
   input  logic                            mem_ready,
   output logic [N_MASTERS-1:0]            grant
);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [MW-1:0]       gidx_q, gidx_d;
   logic [MW-1:0]       ptr_q, ptr_d;

   logic                busy;
   logic                owner_valid;
   logic                owner_lock;
   logic [MW-1:0]       gidx_inc;

   // Round-robin selection
   logic [2*N_MASTERS-1:0] rr_dbl;
   logic [N_MASTERS-1:0]   rr_rot;
   logic [MW:0]            rr_pos;
   logic [MW:0]            rr_sum;
   logic [MW-1:0]          rr_sel;
   logic                   rr_any;

   assign busy = (state_q == BUSY);

   // Rotating the request vector so that bit 0 is the master at ptr turns
   // "first requester at or after ptr, with wrap" into a plain lowest-set-bit
   // search. The found offset is then added back to ptr modulo N_MASTERS.
   always_comb begin
      rr_dbl = {m_valid, m_valid} >> ptr_q;
      rr_rot = rr_dbl[N_MASTERS-1:0];
      rr_any = |m_valid;
      rr_pos = '0;
      for (int i = N_MASTERS - 1; i >= 0; i--) begin
         if (rr_rot[i]) begin
            rr_pos = (MW+1)'(i);
         end
      end
      rr_sum = {1'b0, ptr_q} + rr_pos;
      if (rr_sum >= (MW+1)'(N_MASTERS)) begin
         rr_sum = rr_sum - (MW+1)'(N_MASTERS);
      end
      rr_sel = rr_sum[MW-1:0];
   end

   // Owner's request fields, selected by the registered owner index
   always_comb begin
      owner_valid = 1'b0;
      owner_lock  = 1'b0;
      mem_addr    = '0;
      mem_wdata   = '0;
      mem_wstrb   = '0;
      for (int i = 0; i < N_MASTERS; i++) begin
         if (gidx_q == MW'(i)) begin
            owner_valid = m_valid[i];
            owner_lock  = m_lock[i];
            mem_addr    = m_addr[i*ADDR_W +: ADDR_W];
            mem_wdata   = m_wdata[i*DATA_W +: DATA_W];
            mem_wstrb   = m_wstrb[i*(DATA_W/8) +: (DATA_W/8)];
         end
      end
   end

   // After a released grant the owner drops to lowest priority
   assign gidx_inc = (gidx_q == MW'(N_MASTERS - 1)) ? '0 : gidx_q + MW'(1);

   always_comb begin
      state_d = state_q;
      gidx_d  = gidx_q;
      ptr_d   = ptr_q;
      case (state_q)
         IDLE: begin
            if (rr_any) begin
               gidx_d  = rr_sel;
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (mem_ready) begin
               if (!owner_lock) begin
                  state_d = IDLE;
                  ptr_d   = gidx_inc;
               end
            end else if (!owner_valid && !owner_lock) begin
               // Lock dropped during a gap between beats: give the port up
               state_d = IDLE;
               ptr_d   = gidx_inc;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         gidx_q  <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         gidx_q  <= gidx_d;
         ptr_q   <= ptr_d;
      end
   end

   assign mem_valid = busy & owner_valid;
   assign m_rdata   = mem_rdata;

   generate
      for (genvar gi = 0; gi < N_MASTERS; gi++) begin : g_master
         assign grant[gi]   = busy & (gidx_q == MW'(gi));
         assign m_ready[gi] = busy & mem_ready & (gidx_q == MW'(gi));
      end
   endgenerate

endmodule
